// File: rtl/timer_dev.sv
// Programmable down-counter timer on the bridge device bus: CTRL/PRESET/COUNT
// registers, one-shot or auto-reload, interrupt request when the count expires.
module timer_dev #(
   parameter int COUNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CNT,
      ST_INT
   } state_t;

   localparam logic [1:0] MODE_RELOAD = 2'b01;

   state_t               state_reg, state_next;
   logic [3:0]           ctrl_reg, ctrl_next;
   logic [COUNT_W-1:0]   preset_reg, preset_next;
   logic [COUNT_W-1:0]   count_reg, count_next;
   logic                 irq_pend_reg, irq_pend_next;

   logic                 ctrl_en;
   logic [1:0]           ctrl_mode;
   logic                 ctrl_im;
   logic                 wr_ctrl;
   logic                 wr_preset;
   logic                 bus_unused;

   assign ctrl_en    = ctrl_reg[0];
   assign ctrl_mode  = ctrl_reg[2:1];
   assign ctrl_im    = ctrl_reg[3];
   assign wr_ctrl    = WE && (Addr[3:2] == 2'd0);
   assign wr_preset  = WE && (Addr[3:2] == 2'd1);
   assign bus_unused = ^{Addr[31:4], Addr[1:0], WD};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         ctrl_reg     <= '0;
         preset_reg   <= '0;
         count_reg    <= '0;
         irq_pend_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ctrl_reg     <= ctrl_next;
         preset_reg   <= preset_next;
         count_reg    <= count_next;
         irq_pend_reg <= irq_pend_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ctrl_next     = ctrl_reg;
      preset_next   = preset_reg;
      count_next    = count_reg;
      irq_pend_next = irq_pend_reg;

      // Auto-reload turns the pending flag into a single-cycle pulse.
      if (ctrl_mode == MODE_RELOAD && irq_pend_reg)
         irq_pend_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (ctrl_en)
               state_next = ST_LOAD;
         end
         ST_LOAD: begin
            count_next = preset_reg;
            state_next = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_en) begin
               state_next = ST_IDLE;
            end else if (count_reg > COUNT_W'(1)) begin
               count_next = count_reg - COUNT_W'(1);
            end else begin
               count_next = '0;
               state_next = ST_INT;
            end
         end
         ST_INT: begin
            irq_pend_next = 1'b1;
            if (ctrl_mode == MODE_RELOAD) begin
               state_next = ST_LOAD;
            end else begin
               state_next   = ST_IDLE;
               ctrl_next[0] = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // CPU writes come last so they override the FSM's EN clear and pend set.
      if (wr_ctrl) begin
         ctrl_next     = WD[3:0];
         irq_pend_next = 1'b0;
      end
      if (wr_preset) begin
         preset_next   = WD[COUNT_W-1:0];
         irq_pend_next = 1'b0;
      end
   end

   always_comb begin
      RD = 32'd0;
      case (Addr[3:2])
         2'd0:    RD = {28'd0, ctrl_reg};
         2'd1:    RD = 32'(preset_reg);
         2'd2:    RD = 32'(count_reg);
         default: RD = 32'd0;
      endcase
   end

   assign IRQ = ctrl_im & irq_pend_reg;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus pushes expected RD/IRQ pairs and a
// separate monitor pops and compares them when the read strobe fires.
module tb_timer_dev;

   logic        clk;
   logic        reset;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        IRQ;

   typedef struct {
      string       name;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } sb_t;

   sb_t sb_q[$];
   bit  mon_tick;
   int  errors;
   int  checks;

   timer_dev #(.COUNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .WD    (WD),
      .RD    (RD),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: consumes expectations whenever the stimulus presents a read.
   initial begin
      sb_t e;
      forever begin
         @(mon_tick);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (RD !== e.exp_rd || IRQ !== e.exp_irq) begin
               errors++;
               $display("FAIL %s: got RD=%h IRQ=%b, expected RD=%h IRQ=%b",
                        e.name, RD, IRQ, e.exp_rd, e.exp_irq);
            end else begin
               $display("ok   %s: RD=%h IRQ=%b", e.name, RD, IRQ);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Addr = a;
      WD   = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
      Addr = 32'd0;
      WD   = 32'd0;
      $display("wr   addr=%h data=%h", a, d);
   endtask

   task automatic chk(input string name, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_irq);
      sb_t e;
      e.name    = name;
      e.exp_rd  = exp_rd;
      e.exp_irq = exp_irq;
      Addr = a;
      sb_q.push_back(e);
      #1;
      mon_tick = ~mon_tick;
      #1;
   endtask

   task automatic chk_irq(input string name, input logic exp_irq);
      checks++;
      if (IRQ !== exp_irq) begin
         errors++;
         $display("FAIL %s: got IRQ=%b, expected IRQ=%b", name, IRQ, exp_irq);
      end else begin
         $display("ok   %s: IRQ=%b", name, IRQ);
      end
   endtask

   logic [31:0] ar_count [9] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2};
   logic        ar_irq   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      errors   = 0;
      checks   = 0;
      mon_tick = 1'b0;
      reset    = 1'b1;
      WE       = 1'b0;
      Addr     = 32'd0;
      WD       = 32'd0;

      // Reset
      tick();
      tick();
      reset = 1'b0;
      chk_irq("rst_irq_direct", 1'b0);
      chk("rst_ctrl",   32'h0, 32'd0, 1'b0);
      chk("rst_preset", 32'h4, 32'd0, 1'b0);
      chk("rst_count",  32'h8, 32'd0, 1'b0);
      tick();
      chk("rst_off_c",  32'hC, 32'd0, 1'b0);

      // One-shot, PRESET=3
      wr(32'h4, 32'd3);
      wr(32'h0, 32'h9);
      tick();
      tick();  chk("os_cnt3", 32'h8, 32'd3, 1'b0);
      tick();  chk("os_cnt2", 32'h8, 32'd2, 1'b0);
      tick();  chk("os_cnt1", 32'h8, 32'd1, 1'b0);
      tick();  chk("os_cnt0", 32'h8, 32'd0, 1'b0);
               chk("os_ctrl_pre", 32'h0, 32'h9, 1'b0);
      tick();  chk("os_irq_edge6", 32'h0, 32'h8, 1'b1);
               chk_irq("os_irq_expired_direct", 1'b1);
      tick();
      tick();  chk("os_irq_sticky", 32'h8, 32'd0, 1'b1);
      wr(32'h4, 32'd3);
      chk("os_irq_clr", 32'h0, 32'h8, 1'b0);

      // Auto-reload, PRESET=2
      wr(32'h4, 32'd2);
      wr(32'h0, 32'hB);
      tick();
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("ar_cycle%0d", i), 32'h8, ar_count[i], ar_irq[i]);
      end
      wr(32'h0, 32'h0);
      tick();
      tick();

      // Pause and resume, PRESET=10
      wr(32'h4, 32'd10);
      wr(32'h0, 32'h9);
      tick();
      tick();
      tick();
      wr(32'h0, 32'h8);
      chk("pause_at", 32'h8, 32'd8, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i % 5 == 4)
            chk($sformatf("pause_hold%0d", i), 32'h8, 32'd8, 1'b0);
      end
      wr(32'h0, 32'h9);
      tick();
      tick();
      chk("resume_reload", 32'h8, 32'd10, 1'b0);
      wr(32'h0, 32'h0);
      tick();

      // Masked interrupt and read-only COUNT
      wr(32'h4, 32'd1);
      wr(32'h0, 32'h1);
      tick();
      tick();  chk("mask_cnt1", 32'h8, 32'd1, 1'b0);
      tick();
      tick();  chk("mask_irq0", 32'h0, 32'h0, 1'b0);
      wr(32'h8, 32'h55);
      chk("count_ro", 32'h8, 32'd0, 1'b0);
      wr(32'hC, 32'hFFFF_FFFF);
      chk("off_c_zero", 32'hC, 32'd0, 1'b0);
      chk("preset_kept", 32'h4, 32'd1, 1'b0);

      // Collision: CTRL write during INT
      wr(32'h4, 32'd3);
      wr(32'h0, 32'h9);
      tick();
      tick();
      tick();
      tick();
      tick();
      wr(32'h0, 32'h9);
      chk("coll_ctrl", 32'h0, 32'h9, 1'b0);
      tick();
      tick();  chk("coll_reload", 32'h8, 32'd3, 1'b0);
      tick();  chk("coll_count2", 32'h8, 32'd2, 1'b0);
      tick();
      tick();
      tick();  chk("coll_irq", 32'h0, 32'h8, 1'b1);

      // PRESET=0 expires after 4 edges
      wr(32'h4, 32'd0);
      wr(32'h0, 32'h9);
      tick();
      tick();
      tick();  chk("p0_before", 32'h0, 32'h9, 1'b0);
      tick();  chk("p0_irq", 32'h0, 32'h8, 1'b1);

      // Reset mid-count
      wr(32'h4, 32'd5);
      wr(32'h0, 32'h9);
      tick();
      tick();
      tick();  chk("mid_cnt4", 32'h8, 32'd4, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_ctrl",   32'h0, 32'd0, 1'b0);
      chk("mid_rst_preset", 32'h4, 32'd0, 1'b0);
      chk("mid_rst_count",  32'h8, 32'd0, 1'b0);
      tick();
      tick();
      chk("mid_rst_idle", 32'h8, 32'd0, 1'b0);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
